// File: rtl/mmio_ctrl_pkg.sv
// Shared register map and FSM encoding for the MMIO core-control block.
package mmio_ctrl_pkg;

  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_STATUS    = 1;
  localparam int unsigned REG_CORE_EN   = 2;
  localparam int unsigned REG_IRQ_EN    = 3;
  localparam int unsigned REG_FRAME_CNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse generator: a trigger produces PULSE_LEN high cycles starting
// on the next cycle; a new trigger restarts the full length.
module pulse_stretch #(
  parameter int unsigned PULSE_LEN = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic pulse,
  output logic last
);

  localparam int unsigned CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger)
      cnt_d = CW'(PULSE_LEN);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pulse = (cnt_q != '0);
  // Final high cycle; lets an owner leave its state exactly as the pulse ends.
  assign last  = (cnt_q == CW'(1));

endmodule

// File: rtl/mmio_core_control.sv
// Host-facing control block for the shader cores: register file, start/run FSM,
// frame counter and done/interrupt handling.
module mmio_core_control
  import mmio_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CORE_NUM  = 4,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned PULSE_LEN = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [WIDTH-1:0]    data_write,
  output logic [WIDTH-1:0]    data_read,
  input  logic                done_in,
  output logic                start_pulse,
  output logic                clear_done,
  output logic [CORE_NUM-1:0] core_en,
  output logic                irq
);

  state_t state_q, state_d;

  logic                done_prev_q;
  logic                done_sticky_q, done_sticky_d;
  logic                irq_en_q, irq_en_d;
  logic [CORE_NUM-1:0] core_en_q, core_en_d;
  logic [WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0]    data_read_q, data_read_d;
  logic [WIDTH-1:0]    rd_val;

  logic busy, ctrl_start, status_clear, done_rise, start_last;
  logic unused_clear_last;

  assign busy         = (state_q != ST_IDLE);
  assign ctrl_start   = write && (address == ADDR_W'(REG_CTRL)) && data_write[0]
                        && !busy && (core_en_q != '0);
  assign status_clear = write && (address == ADDR_W'(REG_STATUS)) && data_write[0];
  assign done_rise    = (state_q == ST_RUN) && done_in && !done_prev_q;

  pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_start_pulse (
    .clk     (clk),
    .reset   (reset),
    .trigger (ctrl_start),
    .pulse   (start_pulse),
    .last    (start_last)
  );

  pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_clear_done (
    .clk     (clk),
    .reset   (reset),
    .trigger (status_clear),
    .pulse   (clear_done),
    .last    (unused_clear_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl_start) state_d = ST_START;
      ST_START: if (start_last) state_d = ST_RUN;
      ST_RUN:   if (done_rise)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_W'(REG_CTRL): begin
        rd_val[1] = done_sticky_q;
        rd_val[0] = busy;
      end
      ADDR_W'(REG_STATUS):    rd_val[0] = done_sticky_q;
      ADDR_W'(REG_CORE_EN):   rd_val[CORE_NUM-1:0] = core_en_q;
      ADDR_W'(REG_IRQ_EN):    rd_val[0] = irq_en_q;
      ADDR_W'(REG_FRAME_CNT): rd_val = frame_cnt_q;
      default: ;
    endcase
  end

  always_comb begin
    done_sticky_d = done_sticky_q;
    irq_en_d      = irq_en_q;
    core_en_d     = core_en_q;
    frame_cnt_d   = frame_cnt_q;
    data_read_d   = data_read_q;

    // Set is applied last so a done edge beats a simultaneous host clear.
    if (status_clear || ctrl_start) done_sticky_d = 1'b0;
    if (done_rise) begin
      done_sticky_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + WIDTH'(1);
    end

    if (write && (address == ADDR_W'(REG_CORE_EN)) && !busy)
      core_en_d = CORE_NUM'(data_write);
    if (write && (address == ADDR_W'(REG_IRQ_EN)))
      irq_en_d = data_write[0];

    if (read) data_read_d = rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      done_prev_q   <= 1'b0;
      done_sticky_q <= 1'b0;
      irq_en_q      <= 1'b0;
      core_en_q     <= '1;
      frame_cnt_q   <= '0;
      data_read_q   <= '0;
    end else begin
      state_q       <= state_d;
      done_prev_q   <= done_in;
      done_sticky_q <= done_sticky_d;
      irq_en_q      <= irq_en_d;
      core_en_q     <= core_en_d;
      frame_cnt_q   <= frame_cnt_d;
      data_read_q   <= data_read_d;
    end
  end

  assign data_read = data_read_q;
  assign core_en   = core_en_q;
  assign irq       = done_sticky_q & irq_en_q;

endmodule
